mem_arbiter: RTL and testbench

Shares the single-ported, word-wide simulation memory between the instruction-cache fill port (read-only) and the data-cache port (read or write-back).
Grants one requester at a time for a whole BLOCKSIZE-word burst and sequences the memory's re/we → Valid handshake once per word.
Returns each word to the granted requester with its index, then pulses done.
Sits between the caches and the memory model in arm_pipelined.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_idxctr.sv | 28 ++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and the address helper for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } statetype;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } granttype;

  // Keep the block bits of addr and replace the word-offset field with idx.
  function automatic logic [31:0] blk_addr(input logic [31:0] addr,
                                           input logic [31:0] idx,
                                           input int          idxw);
    logic [31:0] mask;
    mask = (32'd1 << (idxw + 2)) - 32'd1;
    return (addr & ~mask) | ((idx << 2) & mask);
  endfunction

endpackage

// File: rtl/mem_arb_idxctr.sv
// Word-index counter for one burst: clear at grant, step on each memory
// Valid, and flag the final word so the FSM knows when to leave BURST.
module mem_arb_idxctr #(
  parameter int BLOCKSIZE = 4,
  parameter int IDXW      = $clog2(BLOCKSIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            inc,
  output logic [IDXW-1:0] idx,
  output logic            last
);

  assign last = (idx == IDXW'(BLOCKSIZE - 1));

  // Hold at the last index so the granted side still sees it during DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc && !last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port burst arbiter in front of the single-ported word memory.
// The I side only reads; the D side reads or writes back a whole block.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration
// instead of fixed D-over-I priority.
//
// Handshake: a requester raises req and holds it until its done pulse.
// Toward memory, re or we is held high through BURST and each one-cycle
// mem_valid pulse retires exactly one word; mem_a/mem_wd stay stable
// until that pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int BLOCKSIZE = 4,
  localparam int IDXW      = $clog2(BLOCKSIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [31:0]     i_addr,
  output logic [31:0]     i_rd,
  output logic            i_wordvalid,
  output logic [IDXW-1:0] i_wordidx,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [31:0]     d_addr,
  input  logic [31:0]     d_wd,
  output logic [31:0]     d_rd,
  output logic            d_wordvalid,
  output logic [IDXW-1:0] d_wordidx,
  output logic            d_done,
  output logic            mem_re,
  output logic            mem_we,
  output logic [31:0]     mem_a,
  output logic [31:0]     mem_wd,
  input  logic [31:0]     mem_rd,
  input  logic            mem_valid,
  output logic [1:0]      dbg_state
);

  statetype        state;
  granttype        gnt;
  logic            we_lat;
  logic [31:0]     addr_lat;
  logic [IDXW-1:0] idx;
  logic            last;
  logic            any_req;
  logic            grant_d;
  logic            in_burst;
  logic            active;
  logic            is_d;

  assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  granttype last_gnt;

  // On a tie, the side that did not win last time gets the bus.
  assign grant_d = d_req & (~i_req | (last_gnt == GNT_I));

  // Remember who won each arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= GNT_I;
    end else if (state == IDLE && any_req) begin
      last_gnt <= grant_d ? GNT_D : GNT_I;
    end
  end
`else
  assign grant_d = d_req;
`endif

  mem_arb_idxctr #(.BLOCKSIZE(BLOCKSIZE), .IDXW(IDXW)) u_idxctr (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE && any_req),
    .inc   (state == BURST && mem_valid),
    .idx   (idx),
    .last  (last)
  );

  // Burst sequencer: grant and latch in IDLE, one word per Valid in BURST,
  // one quiet cycle in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= GNT_I;
      we_lat   <= 1'b0;
      addr_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt      <= grant_d ? GNT_D : GNT_I;
            we_lat   <= grant_d & d_we;
            addr_lat <= grant_d ? d_addr : i_addr;
            state    <= BURST;
          end
        end
        BURST: begin
          if (mem_valid && last) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_burst = (state == BURST);
  assign active   = (state != IDLE);
  assign is_d     = (gnt == GNT_D);

  assign mem_re = in_burst & ~(is_d & we_lat);
  assign mem_we = in_burst & is_d & we_lat;
  assign mem_a  = in_burst ? blk_addr(addr_lat, 32'(idx), IDXW) : '0;
  assign mem_wd = mem_we ? d_wd : '0;

  assign i_rd        = mem_rd;
  assign d_rd        = mem_rd;
  assign i_wordvalid = mem_valid & in_burst & ~is_d;
  assign d_wordvalid = mem_valid & in_burst & is_d & ~we_lat;
  assign i_wordidx   = (active & ~is_d) ? idx : '0;
  assign d_wordidx   = (active & is_d) ? idx : '0;
  assign i_done      = (state == DONE) & ~is_d;
  assign d_done      = (state == DONE) & is_d;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a burst table plus hand-written sequences
// for contention, mid-burst changes, reset and back-to-back bursts.
module tb_mem_arbiter;

  localparam int BS  = 4;
  localparam int LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wd, wd_base;
  logic [31:0] i_rd, d_rd, mem_a, mem_wd;
  logic        i_wordvalid, d_wordvalid, i_done, d_done, mem_re, mem_we;
  logic [1:0]  i_wordidx, d_wordidx, dbg_state;
  logic [31:0] mem_rd    = '0;
  logic        mem_valid = 1'b0;

  assign d_wd = wd_base + 32'(d_wordidx);

  mem_arbiter #(.BLOCKSIZE(BS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rd(i_rd), .i_wordvalid(i_wordvalid),
    .i_wordidx(i_wordidx), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd), .d_rd(d_rd),
    .d_wordvalid(d_wordvalid), .d_wordidx(d_wordidx), .d_done(d_done),
    .mem_re(mem_re), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .mem_valid(mem_valid), .dbg_state(dbg_state)
  );

  // memory model: LAT cycles per word, Valid one cycle, optional stray pulse
  logic [31:0] ram [0:1023];
  int cnt = 0;
  int stray_req = 0;
  int stray_done = 0;
  always @(posedge clk) begin
    #1;
    if (mem_valid) begin
      mem_valid = 1'b0;
      mem_rd    = '0;
      cnt       = 0;
    end else if (stray_req != stray_done) begin
      mem_valid  = 1'b1;
      mem_rd     = 32'h5555_5555;
      stray_done = stray_req;
    end else if (mem_re || mem_we) begin
      cnt++;
      if (cnt >= LAT) begin
        mem_valid = 1'b1;
        cnt       = 0;
        if (mem_we) ram[mem_a[11:2]] = mem_wd;
        else        mem_rd = ram[mem_a[11:2]];
      end
    end else begin
      cnt = 0;
    end
  end

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [31:0] acc_q[$], wr_q[$], iw_q[$], dw_q[$];
  logic [1:0]  ii_q[$], di_q[$];
  int i_done_n = 0, d_done_n = 0, valid_n = 0;
  int i_snap = 0, d_snap = 0, v_snap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: sample mid-cycle, log accesses and returned words
  always @(negedge clk) begin
    if (mem_valid) valid_n++;
    if (mem_valid && (mem_re || mem_we)) begin
      acc_q.push_back(mem_a);
      if (mem_we) wr_q.push_back(mem_wd);
    end
    if (i_wordvalid) begin iw_q.push_back(i_rd); ii_q.push_back(i_wordidx); end
    if (d_wordvalid) begin dw_q.push_back(d_rd); di_q.push_back(d_wordidx); end
    if (i_done) i_done_n++;
    if (d_done) d_done_n++;
    if (i_done || d_done) check("enables_in_done", 32'({mem_re, mem_we}), 32'd0);
    if (i_wordvalid && d_wordvalid) check("both_wordvalid", 32'd1, 32'd0);
  end

  // driver tasks
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q;
    acc_q.delete(); wr_q.delete(); iw_q.delete(); dw_q.delete();
    ii_q.delete(); di_q.delete();
    i_snap = i_done_n; d_snap = d_done_n; v_snap = valid_n;
  endtask

  task automatic wait_done(input logic is_d);
    int n = 0;
    while (!(is_d ? d_done : i_done) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check(is_d ? "d_done_timeout" : "i_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_burst(input logic is_d, input logic we, input logic [31:0] blk,
                             input logic [31:0] d0, input logic [31:0] step,
                             input int n_i, input int n_d);
    check("acc_count", 32'(acc_q.size()), 32'(BS));
    for (int k = 0; k < BS; k++)
      if (k < acc_q.size()) check("mem_a", acc_q[k], blk + 32'(4 * k));
    if (we) begin
      check("wr_count", 32'(wr_q.size()), 32'(BS));
      for (int k = 0; k < BS; k++)
        if (k < wr_q.size()) check("mem_wd", wr_q[k], d0 + 32'(k) * step);
      check("d_wv_on_write", 32'(dw_q.size()), 32'd0);
    end else if (is_d) begin
      check("d_word_count", 32'(dw_q.size()), 32'(BS));
      for (int k = 0; k < BS; k++)
        if (k < dw_q.size()) begin
          check("d_rd", dw_q[k], d0 + 32'(k) * step);
          check("d_wordidx", 32'(di_q[k]), 32'(k));
        end
      check("i_wv_in_d_burst", 32'(iw_q.size()), 32'd0);
    end else begin
      check("i_word_count", 32'(iw_q.size()), 32'(BS));
      for (int k = 0; k < BS; k++)
        if (k < iw_q.size()) begin
          check("i_rd", iw_q[k], d0 + 32'(k) * step);
          check("i_wordidx", 32'(ii_q[k]), 32'(k));
        end
      check("d_wv_in_i_burst", 32'(dw_q.size()), 32'd0);
    end
    check("i_done_count", 32'(i_done_n - i_snap), 32'(n_i));
    check("d_done_count", 32'(d_done_n - d_snap), 32'(n_d));
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_blk;
    logic [31:0] exp_d0;
    logic [31:0] exp_step;
  } vec_t;

  task automatic run_vec(input vec_t v);
    clear_q();
    wd_base = v.wd;
    if (v.is_d) begin d_addr = v.addr; d_we = v.we; d_req = 1'b1; end
    else begin i_addr = v.addr; i_req = 1'b1; end
    wait_done(v.is_d);
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    check_burst(v.is_d, v.we, v.exp_blk, v.exp_d0, v.exp_step,
                v.is_d ? 0 : 1, v.is_d ? 1 : 0);
    d_we = 1'b0;
  endtask

  vec_t vecs [7];
  int   order[$];
  int   gap;
  int   n;
  logic changed;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'h100, 32'hA000_0100, 32'd4};
    vecs[1] = '{1'b1, 1'b1, 32'h200, 32'hDEAD0000, 32'h200, 32'hDEAD_0000, 32'd1};
    vecs[2] = '{1'b1, 1'b0, 32'h20C, 32'h0,        32'h200, 32'hDEAD_0000, 32'd1};
    vecs[3] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        32'h3F0, 32'hA000_03F0, 32'd4};
    vecs[4] = '{1'b1, 1'b0, 32'h048, 32'h0,        32'h040, 32'hA000_0040, 32'd4};
    vecs[5] = '{1'b1, 1'b1, 32'h500, 32'h12340000, 32'h500, 32'h1234_0000, 32'd1};
    vecs[6] = '{1'b0, 1'b0, 32'h50C, 32'h0,        32'h500, 32'h1234_0000, 32'd1};
    for (int w = 0; w < 1024; w++) ram[w] = 32'hA000_0000 + 32'(4 * w);

    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; wd_base = '0;
    tick(); tick();
    check("rst_ctrl", 32'({mem_re, mem_we, i_wordvalid, d_wordvalid, i_done, d_done}), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_idx", 32'({i_wordidx, d_wordidx}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    tick();

    // table of single bursts
    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // contention: D first, no I words while D owns the bus, then I
    clear_q();
    i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    wait_done(1'b1);
    check("contend_no_i_words", 32'(iw_q.size()), 32'd0);
    check("contend_d_words", 32'(dw_q.size()), 32'(BS));
    check("contend_i_not_done", 32'(i_done_n - i_snap), 32'd0);
    d_req = 1'b0;
    wait_done(1'b0);
    i_req = 1'b0;
    tick(); tick();
    check("contend_acc_count", 32'(acc_q.size()), 32'(2 * BS));
    for (int k = 0; k < 2 * BS; k++)
      if (k < acc_q.size())
        check("contend_mem_a", acc_q[k], (k < BS) ? 32'h200 + 32'(4 * k)
                                                   : 32'h100 + 32'(4 * (k - BS)));
    for (int k = 0; k < BS; k++) begin
      if (k < dw_q.size()) check("contend_d_rd", dw_q[k], 32'hDEAD_0000 + 32'(k));
      if (k < iw_q.size()) check("contend_i_rd", iw_q[k], 32'hA000_0100 + 32'(4 * k));
    end

    // both requests held: grant order over four bursts
    clear_q();
    i_req = 1'b1; d_req = 1'b1;
    n = 0;
    while (order.size() < 4 && n < 600) begin
      tick();
      n++;
      if (d_done) order.push_back(1);
      if (i_done) order.push_back(0);
      if (order.size() >= 4) begin i_req = 1'b0; d_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("order_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < order.size())
`ifdef MEM_ARB_RR_EN
        check("rr_order", 32'(order[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
`else
        check("fixed_order", 32'(order[k]), 32'd1);
`endif
    tick(); tick();

    // mid-burst address / we change and early req drop are ignored
    clear_q();
    d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1; changed = 1'b0;
    n = 0;
    while (!d_done && n < 300) begin
      tick();
      n++;
      if (dw_q.size() >= 2 && !changed) begin d_addr = 32'h300; d_we = 1'b1; changed = 1'b1; end
      if (dw_q.size() >= 3) d_req = 1'b0;
    end
    if (n >= 300) check("midburst_timeout", 32'd1, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick(); tick();
    check_burst(1'b1, 1'b0, 32'h200, 32'hDEAD_0000, 32'd1, 0, 1);
    check("midburst_no_write", 32'(wr_q.size()), 32'd0);

    // reset in the middle of a burst
    clear_q();
    i_addr = 32'h100; i_req = 1'b1;
    n = 0;
    while (iw_q.size() < 2 && n < 300) begin tick(); n++; end
    tick();
    reset = 1'b0; i_req = 1'b0;
    #1;
    check("midrst_ctrl", 32'({mem_re, mem_we, i_wordvalid, d_wordvalid, i_done, d_done}), 32'd0);
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_mem_wd", mem_wd, 32'd0);
    check("midrst_idx", 32'({i_wordidx, d_wordidx}), 32'd0);
    check("midrst_i_rd", i_rd, 32'd0);
    check("midrst_words_kept", 32'(iw_q.size()), 32'd2);
    tick();
    reset = 1'b1;
    tick(); tick();
    // stray Valid while idle
    clear_q();
    stray_req++;
    tick(); tick(); tick();
    check("stray_seen", 32'(valid_n - v_snap), 32'd1);
    check("stray_no_words", 32'(iw_q.size() + dw_q.size()), 32'd0);
    check("stray_no_access", 32'(acc_q.size()), 32'd0);
    check("stray_no_done", 32'((i_done_n - i_snap) + (d_done_n - d_snap)), 32'd0);
    run_vec(vecs[0]);

    // back-to-back I bursts with req held through done
    clear_q();
    i_addr = 32'h100; i_req = 1'b1;
    wait_done(1'b0);
    gap = 1;
    n = 0;
    do begin
      tick();
      n++;
      if (!mem_re) gap++;
    end while (!mem_re && n < 20);
    check("b2b_gap", 32'(gap), 32'd2);
    wait_done(1'b0);
    i_req = 1'b0;
    tick(); tick();
    check("b2b_words", 32'(iw_q.size()), 32'(2 * BS));
    check("b2b_done_count", 32'(i_done_n - i_snap), 32'd2);
    for (int k = 0; k < 2 * BS; k++)
      if (k < iw_q.size()) begin
        check("b2b_i_rd", iw_q[k], 32'hA000_0100 + 32'(4 * (k % BS)));
        check("b2b_idx", 32'(ii_q[k]), 32'(k % BS));
      end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
